// File: rtl/controller_sequencer.sv
// Controller-sequencer: six-state one-hot ring (T1-T6) decoded with the IR opcode into the 12-bit control word.
// Control outputs are combinational from ring/halt state; HLT at T4 freezes the ring until clear.
module controller_sequencer (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] opcode,
   output logic       cp,
   output logic       ep,
   output logic       n_lm,
   output logic       n_ce,
   output logic       n_li,
   output logic       n_ei,
   output logic       n_la,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       n_lb,
   output logic       n_lo,
   output logic [5:0] t_state,
   output logic       halted
);

   typedef struct packed {
      logic cp;
      logic ep;
      logic n_lm;
      logic n_ce;
      logic n_li;
      logic n_ei;
      logic n_la;
      logic ea;
      logic su;
      logic eu;
      logic n_lb;
      logic n_lo;
   } ctrl_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [5:0] ring_q, ring_d;
   logic       halted_q, halted_d;
   ctrl_t      ctrl;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         ring_q   <= 6'b000001;
         halted_q <= 1'b0;
      end else begin
         ring_q   <= ring_d;
         halted_q <= halted_d;
      end
   end

   // HLT is taken on the edge that would close T4, so the ring parks on T4.
   always_comb begin
      ring_d   = ring_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (ring_q[3] && opcode == OP_HLT) begin
            halted_d = 1'b1;
         end else begin
            ring_d = {ring_q[4:0], ring_q[5]};
         end
      end
   end

   always_comb begin
      ctrl = '{cp: 1'b0, ep: 1'b0, n_lm: 1'b1, n_ce: 1'b1, n_li: 1'b1, n_ei: 1'b1,
               n_la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, n_lb: 1'b1, n_lo: 1'b1};
      if (!clear && !halted_q) begin
         if (ring_q[0]) begin
            ctrl.ep   = 1'b1;
            ctrl.n_lm = 1'b0;
         end else if (ring_q[1]) begin
            ctrl.cp = 1'b1;
         end else if (ring_q[2]) begin
            ctrl.n_ce = 1'b0;
            ctrl.n_li = 1'b0;
         end else if (ring_q[3]) begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctrl.n_lm = 1'b0;
                  ctrl.n_ei = 1'b0;
               end
               OP_OUT: begin
                  ctrl.ea   = 1'b1;
                  ctrl.n_lo = 1'b0;
               end
               default: ;
            endcase
         end else if (ring_q[4]) begin
            case (opcode)
               OP_LDA: begin
                  ctrl.n_ce = 1'b0;
                  ctrl.n_la = 1'b0;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.n_ce = 1'b0;
                  ctrl.n_lb = 1'b0;
               end
               default: ;
            endcase
         end else if (ring_q[5]) begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               ctrl.eu   = 1'b1;
               ctrl.n_la = 1'b0;
               ctrl.su   = (opcode == OP_SUB);
            end
         end
      end
   end

   assign cp      = ctrl.cp;
   assign ep      = ctrl.ep;
   assign n_lm    = ctrl.n_lm;
   assign n_ce    = ctrl.n_ce;
   assign n_li    = ctrl.n_li;
   assign n_ei    = ctrl.n_ei;
   assign n_la    = ctrl.n_la;
   assign ea      = ctrl.ea;
   assign su      = ctrl.su;
   assign eu      = ctrl.eu;
   assign n_lb    = ctrl.n_lb;
   assign n_lo    = ctrl.n_lo;
   assign t_state = ring_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed and random bench for controller_sequencer; expected words are queued when inputs are driven.
module tb_controller_sequencer;

   logic       clk = 1'b0;
   logic       clear;
   logic [3:0] opcode;
   logic       cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;
   logic [5:0] t_state;
   logic       halted;

   int checks   = 0;
   int failures = 0;

   int m_t    = 1;
   bit m_halt = 1'b0;

   logic [18:0] exp_q[$];

   localparam logic [11:0] IDLE = 12'b0011_1110_0011;

   controller_sequencer dut (
      .clk(clk), .clear(clear), .opcode(opcode),
      .cp(cp), .ep(ep), .n_lm(n_lm), .n_ce(n_ce), .n_li(n_li), .n_ei(n_ei),
      .n_la(n_la), .ea(ea), .su(su), .eu(eu), .n_lb(n_lb), .n_lo(n_lo),
      .t_state(t_state), .halted(halted)
   );

   always #5 clk = ~clk;

   // Word layout: {t_state, halted, cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo}
   function automatic logic [18:0] model_word(int t, bit h, bit clr, logic [3:0] op);
      logic [11:0] c;
      logic [5:0]  ts;
      c  = IDLE;
      ts = 6'b000001 << (t - 1);
      if (!clr && !h) begin
         case (t)
            1: c = 12'b0101_1110_0011;
            2: c = 12'b1011_1110_0011;
            3: c = 12'b0010_0110_0011;
            4: if (op <= 4'h2)      c = 12'b0001_1010_0011;
               else if (op == 4'hE) c = 12'b0011_1111_0010;
            5: if (op == 4'h0)      c = 12'b0010_1100_0011;
               else if (op <= 4'h2) c = 12'b0010_1110_0001;
            6: if (op == 4'h1)      c = 12'b0011_1100_0111;
               else if (op == 4'h2) c = 12'b0011_1100_1111;
            default: ;
         endcase
      end
      if (clr) ts = 6'b000001;
      return {ts, h, c};
   endfunction

   task automatic expect_now();
      exp_q.push_back(model_word(m_t, m_halt, clear, opcode));
   endtask

   task automatic compare(string tag);
      logic [18:0] obs, expv;
      obs = {t_state, halted, cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         expv = exp_q.pop_front();
         assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
         end
      end
   endtask

   task automatic check_bit(string tag, logic obs, logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (clear) begin
         m_t = 1; m_halt = 1'b0;
      end else if (!m_halt) begin
         if (m_t == 4 && opcode == 4'hF) m_halt = 1'b1;
         else m_t = (m_t == 6) ? 1 : m_t + 1;
      end
      #1 expect_now();
      #1 compare(tag);
   endtask

   task automatic set_clear(logic v, string tag);
      clear = v;
      if (v) begin
         m_t = 1; m_halt = 1'b0;
      end
      #1 expect_now();
      #1 compare(tag);
   endtask

   task automatic set_op(logic [3:0] op, string tag);
      opcode = op;
      #1 expect_now();
      #1 compare(tag);
   endtask

   task automatic seek(int t);
      for (int i = 0; i < 6 && m_t != t; i++) step("seek");
   endtask

   initial begin
      clear  = 1'b1;
      opcode = 4'h0;
      #1 expect_now();
      #1 compare("reset_async");
      step("reset_held");
      set_clear(1'b0, "release_t1");
      check_bit("release_ep", ep, 1'b1);
      step("first_t2");
      check_bit("first_t2_cp", cp, 1'b1);

      // LDA through a full instruction and back to T1
      seek(1);
      for (int i = 0; i < 6; i++) step("lda");
      check_bit("lda_wrap_t1", t_state[0], 1'b1);

      // ADD, cut by clear in the middle of T5
      set_op(4'h1, "add_op");
      for (int i = 0; i < 4; i++) step("add_to_t5");
      check_bit("add_t5_n_lb", n_lb, 1'b0);
      set_clear(1'b1, "clear_mid_t5");
      check_bit("clear_mid_t5_n_ce", n_ce, 1'b1);
      set_clear(1'b0, "release_after_t5");
      step("after_clear_t2");

      seek(1);
      for (int i = 0; i < 6; i++) begin
         step("add");
         if (m_t == 6) check_bit("add_t6_su", su, 1'b0);
      end
      set_op(4'h2, "sub_op");
      for (int i = 0; i < 6; i++) begin
         step("sub");
         if (m_t == 6) check_bit("sub_t6_su", su, 1'b1);
         else check_bit("sub_su_other", su, 1'b0);
      end

      set_op(4'hE, "out_op");
      for (int i = 0; i < 6; i++) begin
         step("out");
         if (m_t == 4) check_bit("out_t4_n_lo", n_lo, 1'b0);
      end
      set_op(4'h7, "nop_op");
      for (int i = 0; i < 7; i++) step("nop");

      // HLT: park at T4 for ten edges, ignore opcode, recover via clear
      seek(1);
      set_op(4'hF, "hlt_op");
      for (int i = 0; i < 13; i++) step("hlt");
      check_bit("hlt_halted", halted, 1'b1);
      check_bit("hlt_t4", t_state[3], 1'b1);
      set_op(4'h0, "hlt_op_change");
      step("hlt_op_change_edge");
      set_clear(1'b1, "hlt_clear");
      set_clear(1'b0, "hlt_release");
      step("hlt_resume_t2");

      for (int i = 0; i < 1000; i++) begin
         opcode = 4'($urandom_range(0, 15));
         if (clear) clear = 1'b0;
         else if ($urandom_range(0, 49) == 0) begin
            clear = 1'b1; m_t = 1; m_halt = 1'b0;
         end
         #1 expect_now();
         #1 compare("rand_async");
         step("rand_edge");
         checks++;
         assert ($onehot(t_state)) else begin
            failures++;
            $error("FAIL rand_onehot observed=%b expected=onehot", t_state);
         end
         checks++;
         assert ((32'(ep) + 32'(!n_ce) + 32'(!n_ei) + 32'(ea) + 32'(eu)) <= 1) else begin
            failures++;
            $error("FAIL rand_bus_drivers observed=%b%b%b%b%b expected=at_most_one", ep, !n_ce, !n_ei, ea, eu);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
